// File: rtl/mips_pkg.sv
// Shared types for the MEM/WB back half of the MIPS pipeline: access-size
// encodings, pipeline register bundles and lane helpers.
package mips_pkg;

  localparam logic [1:0] LM_WORD  = 2'b00;
  localparam logic [1:0] LM_HALF  = 2'b01;
  localparam logic [1:0] LM_BYTE  = 2'b10;
  localparam logic [1:0] LM_BYTEU = 2'b11;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic [1:0]  load_mode;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] write_data;
    logic [4:0]  write_reg;
    logic        reg_write;
    logic [1:0]  load_mode;
  } mem_wb_t;

  function automatic logic is_misaligned(input logic [1:0] lm, input logic [1:0] addr_lo);
    return ((lm == LM_WORD) && (addr_lo != 2'b00)) ||
           ((lm == LM_HALF) && addr_lo[0]);
  endfunction

  // Little-endian lane pick followed by sign or zero extension.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  lm,
                                               input logic [1:0]  addr_lo);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    byte_v = word[{addr_lo, 3'b000} +: 8];
    case (lm)
      LM_HALF:  return {{16{half_v[15]}}, half_v};
      LM_BYTE:  return {{24{byte_v[7]}}, byte_v};
      LM_BYTEU: return {24'h0, byte_v};
      default:  return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX-side inputs and WB-side outputs of mem_wb_stage.
// ALIGN_ERR exists only when MEM_WB_ALIGN_CHECK_EN is defined.
interface mem_wb_stage_if;
  import mips_pkg::*;

  logic        EX_VALID;
  logic [31:0] ALU_RESULT;
  logic [31:0] STORE_DATA;
  logic [4:0]  DEST_REG;
  logic        RegWrite;
  logic        MemWrite;
  logic        MemRead;
  logic        MemToReg;
  logic [1:0]  load_mode;
  logic        STALL;

  logic [5:0]  WB_WRITE_REG;
  logic [31:0] WB_WRITE_DATA;
  logic        WB_RegWrite;
  logic [1:0]  WB_load_mode;
`ifdef MEM_WB_ALIGN_CHECK_EN
  logic        ALIGN_ERR;
`endif

  modport master (
    output EX_VALID, ALU_RESULT, STORE_DATA, DEST_REG,
    output RegWrite, MemWrite, MemRead, MemToReg, load_mode, STALL,
    input  WB_WRITE_REG, WB_WRITE_DATA, WB_RegWrite, WB_load_mode
`ifdef MEM_WB_ALIGN_CHECK_EN
    , input ALIGN_ERR
`endif
  );

  modport slave (
    input  EX_VALID, ALU_RESULT, STORE_DATA, DEST_REG,
    input  RegWrite, MemWrite, MemRead, MemToReg, load_mode, STALL,
    output WB_WRITE_REG, WB_WRITE_DATA, WB_RegWrite, WB_load_mode
`ifdef MEM_WB_ALIGN_CHECK_EN
    , output ALIGN_ERR
`endif
  );

endinterface

// File: rtl/data_memory.sv
// Word-organised data RAM: byte-enabled synchronous write, combinational read.
module data_memory #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] index,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/mem_wb_stage.sv
// EX/MEM register, data-memory access and MEM/WB register of the MIPS pipeline.
// Define MEM_WB_ALIGN_CHECK_EN to enable the misaligned-access check and ALIGN_ERR.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DMEM_DEPTH = 256,
  parameter int DATA_W     = 32
) (
  input logic           CLK,
  input logic           RST,
  mem_wb_stage_if.slave bus
);

  localparam int AW = $clog2(DMEM_DEPTH);

  ex_mem_t             ex_mem;
  mem_wb_t             mem_wb;
  logic [AW-1:0]       word_index;
  logic [3:0]          byte_en;
  logic [31:0]         store_word;
  logic [31:0]         mem_rdata;
  logic [DATA_W-1:0]   load_data;
  logic [DATA_W-1:0]   wb_data;
  logic                mem_we;
  logic                wb_reg_write;
  logic                access_bad;

  // A bubble clears everything, so WB shows an all-zero bundle for it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_mem <= '0;
    end else if (!bus.STALL) begin
      if (bus.EX_VALID) begin
        ex_mem <= '{valid:      1'b1,
                    alu_result: bus.ALU_RESULT,
                    store_data: bus.STORE_DATA,
                    dest_reg:   bus.DEST_REG,
                    reg_write:  bus.RegWrite,
                    mem_write:  bus.MemWrite,
                    mem_read:   bus.MemRead,
                    mem_to_reg: bus.MemToReg,
                    load_mode:  bus.load_mode};
      end else begin
        ex_mem <= '0;
      end
    end
  end

  assign word_index = ex_mem.alu_result[AW+1:2];

  always_comb begin
    byte_en    = 4'b0000;
    store_word = ex_mem.store_data;
    case (ex_mem.load_mode)
      LM_WORD: byte_en = 4'b1111;
      LM_HALF: begin
        byte_en    = ex_mem.alu_result[1] ? 4'b1100 : 4'b0011;
        store_word = {2{ex_mem.store_data[15:0]}};
      end
      default: begin
        byte_en    = 4'b0001 << ex_mem.alu_result[1:0];
        store_word = {4{ex_mem.store_data[7:0]}};
      end
    endcase
  end

`ifdef MEM_WB_ALIGN_CHECK_EN
  assign access_bad = ex_mem.valid && (ex_mem.mem_read || ex_mem.mem_write) &&
                      is_misaligned(ex_mem.load_mode, ex_mem.alu_result[1:0]);
`else
  assign access_bad = 1'b0;
`endif

  assign mem_we = ex_mem.valid && ex_mem.mem_write && !bus.STALL && !access_bad;

  data_memory #(.DEPTH(DMEM_DEPTH), .AW(AW)) u_dmem (
    .clk   (CLK),
    .we    (mem_we),
    .be    (byte_en),
    .index (word_index),
    .wdata (store_word),
    .rdata (mem_rdata)
  );

  // Read sees pre-write contents when MemRead and MemWrite are both set.
  assign load_data = ex_mem.mem_read ?
                     extract_lane(mem_rdata, ex_mem.load_mode, ex_mem.alu_result[1:0]) : '0;

  assign wb_data = ex_mem.mem_to_reg ? load_data : ex_mem.alu_result;

  assign wb_reg_write = ex_mem.valid && ex_mem.reg_write && (ex_mem.dest_reg != 5'd0) &&
                        !(access_bad && ex_mem.mem_read);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_wb <= '0;
    end else if (!bus.STALL) begin
      mem_wb <= '{write_data: wb_data,
                  write_reg:  ex_mem.dest_reg,
                  reg_write:  wb_reg_write,
                  load_mode:  ex_mem.load_mode};
    end
  end

`ifdef MEM_WB_ALIGN_CHECK_EN
  logic align_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                           align_err <= 1'b0;
    else if (!bus.STALL && access_bad) align_err <= 1'b1;
  end

  assign bus.ALIGN_ERR = align_err;
`endif

  assign bus.WB_WRITE_REG  = {1'b0, mem_wb.write_reg};
  assign bus.WB_WRITE_DATA = mem_wb.write_data;
  assign bus.WB_RegWrite   = mem_wb.reg_write;
  assign bus.WB_load_mode  = mem_wb.load_mode;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Back half of the MIPS pipeline. It registers EX-stage results into an EX/MEM register, performs the data-memory access, and registers the outcome into a MEM/WB register. It produces the write-back bundle consumed by `ID_Stage`: `delay_write_register`, `delay_write_data`, `delay_in_RegWrite` and `delay_in_load_mode`. It is the producer end of the register-file write port that `ID_Stage` receives.

## Interface
Parameters:
- `DMEM_DEPTH`, default 256: data memory depth in 32-bit words; power of two.
- `DATA_W`, default 32: datapath width; only 32 is supported.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `EX_VALID` in 1: the EX inputs carry a real instruction; 0 means bubble.
- `ALU_RESULT` in 32: ALU result, or the effective byte address for loads and stores.
- `STORE_DATA` in 32: rt value for stores.
- `DEST_REG` in 5: destination register, already chosen by RegDst.
- `RegWrite`, `MemWrite`, `MemRead`, `MemToReg` in 1 each: control bits from ID.
- `load_mode` in 2: access size, encoded as described under Operation.
- `STALL` in 1: freeze request.
- `WB_WRITE_REG` out 6: write-back register. Bits [4:0] carry `DEST_REG`; bit 5 is always 0.
- `WB_WRITE_DATA` out 32: write-back data.
- `WB_RegWrite` out 1: register-file write enable.
- `WB_load_mode` out 2: `load_mode` delayed to the WB stage.
- `ALIGN_ERR` out 1: present only with `MEM_WB_ALIGN_CHECK_EN`.

## Operation
- **EX/MEM register:** captures all inputs every edge while `STALL` is 0. A bubble (`EX_VALID` = 0) clears the captured valid bit and all control bits.
- **Word index:** `ALU_RESULT[log2(DMEM_DEPTH)+1:2]`. Higher address bits are ignored, so addresses wrap modulo the memory size.
- **load_mode encoding:**
  - 00: word.
  - 01: halfword, sign-extended. Lane selected by `addr[1]`.
  - 10: byte, sign-extended. Lane selected by `addr[1:0]`.
  - 11: byte, zero-extended.
  - Little-endian lanes throughout.
- **Stores:** a valid `MemWrite` with `STALL` = 0 writes the selected lanes only, using per-byte enables; the other lanes are untouched. Store size is 00 word, 01 half, 10/11 byte, with the data taken from the low bits of `STORE_DATA`, shifted into the selected lane.
- **Loads:** a valid `MemRead` reads combinationally during the MEM cycle; the lane is extracted and extended there.
- **MemRead and MemWrite both set:** the read returns the pre-write contents and the write still commits.
- **MEM/WB register:** captures the write data, selected as loaded data when `MemToReg` = 1 and the registered `ALU_RESULT` otherwise, plus `DEST_REG`, `RegWrite` ANDed with valid, and `load_mode`.
- **Register 0:** `WB_RegWrite` is forced to 0 when `DEST_REG` = 0.
- **Stall:** `STALL` = 1 holds both registers and suppresses the memory write. The WB outputs stay constant during the stall; the repeated register-file write is idempotent.

## Timing
- **Latency:** an instruction on the EX inputs in cycle N is in MEM during N+1. Its store commits at the end of N+1. WB outputs hold its result for all of cycle N+2, or longer if stalled.
- **Back-to-back store then load** to the same word: the load sees the new data. No hazard stall is required.
- **Reset:** all outputs are 0, and both valid bits and all control bits are 0. Memory contents are not reset.
- **Reset mid-operation:** `RST` asserting before a store's commit edge drops that store. Releasing `RST` takes effect at the first edge after deassertion.

## Configuration
`MEM_WB_ALIGN_CHECK_EN` — misaligned-access check.

With the macro defined:
- A valid load or store is misaligned when it is a word access with `addr[1:0]` ≠ 0, or a halfword access with `addr[0]` = 1.
- A misaligned store suppresses the memory write.
- A misaligned load suppresses `WB_RegWrite`.
- `ALIGN_ERR` is set at the MEM/WB edge and is sticky until `RST`.

Without the macro:
- No `ALIGN_ERR` port exists.
- Low address bits are ignored for word accesses, and `addr[0]` is ignored for halfword accesses.

## Structure
- **Package `mips_pkg`:** `load_mode` encoding constants `LM_WORD`, `LM_HALF`, `LM_BYTE`, `LM_BYTEU`, and a packed struct for the EX/MEM and MEM/WB bundles.
- **Sub-module `data_memory`:** synchronous write with byte enables and combinational read. The lane extraction/extension and the register-0 masking live in `mem_wb_stage` itself.

## Test plan
- **Word round trip:** SW 0xDEADBEEF to address 0x10, then LW into r5 next cycle → two cycles after the LW, `WB_WRITE_REG` = 5, `WB_WRITE_DATA` = 0xDEADBEEF, `WB_RegWrite` = 1.
- **Sub-word stores and loads:** SB 0x80 to 0x13, then load byte signed (10) and byte unsigned (11) from 0x13 → data 0xFFFFFF80 and 0x00000080. The word at 0x10 reads 0x80ADBEEF.
- **Register 0 masking:** R-type with `ALU_RESULT` = 7 and `DEST_REG` = 0 → `WB_RegWrite` = 0. Same instruction with `DEST_REG` = 9 → `WB_WRITE_DATA` = 7, `WB_RegWrite` = 1.
- **Stall:** `STALL` = 1 for 3 cycles with an SW in MEM → memory unchanged and WB outputs constant. The store commits on the first edge with `STALL` = 0.
- **Reset:** assert `RST` asynchronously mid-cycle with an SW in MEM → all outputs 0 immediately and the memory word unchanged.
- **Align check:** with `MEM_WB_ALIGN_CHECK_EN`, LW from 0x12 → `WB_RegWrite` = 0 and `ALIGN_ERR` = 1, staying 1 until `RST`.
